// File: rtl/delta_decoder.sv
// delta_decoder
//   Rebuilds a sample stream from a seed value and a stream of differences.
//   A seed is loaded into the accumulator. Each accepted delta is added to the
//   accumulator modulo 2^DATAWIDTH. The new value is presented on sum one cycle
//   later, through a valid/ready output stage that can accept one delta per cycle.
//
// Parameters
//   DATAWIDTH    : width of seed, delta_in and sum
//   CNTWIDTH     : width of count
//   SIGNED_DELTA : 0 = unsigned deltas (wrap = carry-out)
//                  1 = two's-complement deltas (wrap = signed overflow)
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset
//   seed_load  in   load seed into the accumulator and enter RUN
//   seed       in   reference value captured on seed_load
//   in_valid   in   delta_in is valid
//   delta_in   in   difference sample
//   in_ready   out  delta is accepted this cycle when in_valid is also high
//   out_valid  out  sum / wrap are valid
//   out_ready  in   downstream consumes sum this cycle
//   sum        out  reconstructed value
//   wrap       out  overflow flag of the addition that produced sum
//   count      out  deltas accepted since the last seed or reset (saturating)
//
// States
//   state | meaning
//   IDLE  | no reference held; deltas are ignored
//   RUN   | reference held in acc; deltas are accumulated

module delta_decoder #(
  parameter int DATAWIDTH    = 8,
  parameter int CNTWIDTH     = 16,
  parameter int SIGNED_DELTA = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_load,
  input  logic [DATAWIDTH-1:0] seed,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] delta_in,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 wrap,
  output logic [CNTWIDTH-1:0]  count
);

  localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;
  localparam int                  MSB     = DATAWIDTH - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATAWIDTH-1:0] acc;
  logic [DATAWIDTH:0]   add_full;
  logic [DATAWIDTH-1:0] add_res;
  logic                 add_ovf_s;
  logic                 add_wrap;
  logic                 accept;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake.
  // in_ready is also gated by rst. Without that gate, a RUN-state block would
  // report ready during the reset cycle, even though that delta would be dropped.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;

    if (seed_load) begin
      state_nxt = RUN;
    end

    if ((state == RUN) && !seed_load && !rst && (!out_valid || out_ready)) begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;

  // Adder with both overflow interpretations.
  // SIGNED_DELTA chooses which one is reported on wrap.
  assign add_full  = {1'b0, acc} + {1'b0, delta_in};
  assign add_res   = add_full[MSB:0];
  assign add_ovf_s = (acc[MSB] == delta_in[MSB]) && (add_res[MSB] != acc[MSB]);
  assign add_wrap  = (SIGNED_DELTA != 0) ? add_ovf_s : add_full[DATAWIDTH];

  // Datapath and output stage.
  // A seed leaves sum untouched: only out_valid and wrap are cleared, so the
  // stale value is never presented as valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sum       <= '0;
      wrap      <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
    end else if (seed_load) begin
      acc       <= seed;
      wrap      <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
    end else if (accept) begin
      acc       <= add_res;
      sum       <= add_res;
      wrap      <= add_wrap;
      out_valid <= 1'b1;
      if (count != CNT_MAX) begin
        count <= count + CNTWIDTH'(1);
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delta_decoder.sv
// Testbench for delta_decoder.
// Two instances receive the same stimulus:
//   - u_dut_u : unsigned deltas, 16-bit count
//   - u_dut_s : signed deltas, 3-bit count (small width so saturation is easy to reach)
// The bench runs a directed vector table, then a saturation sequence, then
// randomized traffic checked against an arithmetic reference model.

module tb_delta_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_load;
  logic [7:0] seed;
  logic       in_valid;
  logic [7:0] delta_in;
  logic       out_ready;

  logic        rdy_u, ov_u, wr_u;
  logic [7:0]  sum_u;
  logic [15:0] cnt_u;
  logic        rdy_s, ov_s, wr_s;
  logic [7:0]  sum_s;
  logic [2:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  delta_decoder #(.DATAWIDTH(8), .CNTWIDTH(16), .SIGNED_DELTA(0)) u_dut_u (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .delta_in(delta_in), .in_ready(rdy_u),
    .out_valid(ov_u), .out_ready(out_ready), .sum(sum_u), .wrap(wr_u),
    .count(cnt_u)
  );

  delta_decoder #(.DATAWIDTH(8), .CNTWIDTH(3), .SIGNED_DELTA(1)) u_dut_s (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .delta_in(delta_in), .in_ready(rdy_s),
    .out_valid(ov_s), .out_ready(out_ready), .sum(sum_s), .wrap(wr_s),
    .count(cnt_s)
  );

  typedef struct {
    logic       rst;
    logic       sl;
    logic [7:0] seed;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_rdy;
    logic       e_ov;
    logic [7:0] e_sum;
    logic       e_wu;
    logic       e_ws;
    int         e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic sl, logic [7:0] s, logic iv,
                              logic [7:0] d, logic o, logic e_rdy, logic e_ov,
                              logic [7:0] e_sum, logic e_wu, logic e_ws, int e_cnt);
    vec_t v;
    v.rst = r;  v.sl = sl;  v.seed = s;  v.iv = iv;  v.d = d;  v.ordy = o;
    v.e_rdy = e_rdy;  v.e_ov = e_ov;  v.e_sum = e_sum;
    v.e_wu = e_wu;    v.e_ws = e_ws;  v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic sl, logic [7:0] s, logic iv,
                       logic [7:0] d, logic o);
    rst = r;  seed_load = sl;  seed = s;  in_valid = iv;  delta_in = d;  out_ready = o;
  endtask

  // ---------------- reference model ----------------
  bit       m_ref;
  bit       m_ov;
  int       m_acc;
  int       m_sum;
  bit       m_wu;
  bit       m_ws;
  int       m_cnt_u;
  int       m_cnt_s;

  function automatic int to_signed8(int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic bit model_ready(bit r, bit sl);
    return !r && m_ref && !sl && (!m_ov || out_ready);
  endfunction

  task automatic model_step(bit r, bit sl, int s, bit iv, int d, bit o);
    bit acc_ok;
    int t;
    int ts;
    acc_ok = iv && model_ready(r, sl);
    if (r) begin
      m_ref = 0; m_ov = 0; m_acc = 0; m_sum = 0; m_wu = 0; m_ws = 0;
      m_cnt_u = 0; m_cnt_s = 0;
    end else if (sl) begin
      m_ref = 1; m_acc = s; m_ov = 0; m_wu = 0; m_ws = 0;
      m_cnt_u = 0; m_cnt_s = 0;
    end else if (acc_ok) begin
      t  = m_acc + d;
      ts = to_signed8(m_acc) + to_signed8(d);
      m_sum = t % 256;
      m_acc = m_sum;
      m_wu  = (t > 255);
      m_ws  = (ts > 127) || (ts < -128);
      m_ov  = 1;
      if (m_cnt_u < 65535) m_cnt_u++;
      if (m_cnt_s < 7) m_cnt_s++;
    end else if (m_ov && o) begin
      m_ov = 0;
    end
  endtask

  initial begin
    int csat;
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    //          rst sl seed  iv d      ordy | rdy ov sum   wu ws cnt
    vt.push_back(mk(1, 0, 0,    1, 5,     1,   0,  0, 0,    0, 0, 0)); // 0 in reset
    vt.push_back(mk(0, 0, 0,    1, 5,     1,   0,  0, 0,    0, 0, 0)); // 1 idle ignores delta
    vt.push_back(mk(0, 1, 10,   1, 5,     1,   0,  0, 0,    0, 0, 0)); // 2 seed 10 wins
    vt.push_back(mk(0, 0, 0,    1, 5,     1,   1,  1, 15,   0, 0, 1)); // 3
    vt.push_back(mk(0, 0, 0,    1, 3,     1,   1,  1, 18,   0, 0, 2)); // 4 back-to-back
    vt.push_back(mk(0, 0, 0,    0, 0,     1,   1,  0, 18,   0, 0, 2)); // 5 drain
    vt.push_back(mk(0, 1, 250,  0, 0,     1,   0,  0, 18,   0, 0, 0)); // 6 seed 250
    vt.push_back(mk(0, 0, 0,    1, 10,    1,   1,  1, 4,    1, 0, 1)); // 7 carry
    vt.push_back(mk(0, 0, 0,    1, 1,     1,   1,  1, 5,    0, 0, 2)); // 8 wrap clears
    vt.push_back(mk(0, 0, 0,    0, 0,     1,   1,  0, 5,    0, 0, 2)); // 9
    vt.push_back(mk(0, 1, 100,  0, 0,     1,   0,  0, 5,    0, 0, 0)); // 10 seed 100
    vt.push_back(mk(0, 0, 0,    1, 8'hF6, 1,   1,  1, 90,   1, 0, 1)); // 11 -10 signed
    vt.push_back(mk(0, 1, 120,  1, 20,    1,   0,  0, 90,   0, 0, 0)); // 12 seed wins
    vt.push_back(mk(0, 0, 0,    1, 20,    1,   1,  1, 8'h8C,0, 1, 1)); // 13 signed ovf
    vt.push_back(mk(0, 1, 10,   0, 0,     1,   0,  0, 8'h8C,0, 0, 0)); // 14 seed 10
    vt.push_back(mk(0, 0, 0,    1, 5,     0,   1,  1, 15,   0, 0, 1)); // 15
    vt.push_back(mk(0, 0, 0,    1, 3,     0,   0,  1, 15,   0, 0, 1)); // 16 stall
    vt.push_back(mk(0, 0, 0,    1, 3,     0,   0,  1, 15,   0, 0, 1)); // 17 stall
    vt.push_back(mk(0, 0, 0,    1, 3,     0,   0,  1, 15,   0, 0, 1)); // 18 stall
    vt.push_back(mk(0, 0, 0,    1, 3,     1,   1,  1, 18,   0, 0, 2)); // 19 release
    vt.push_back(mk(0, 1, 7,    1, 9,     0,   0,  0, 18,   0, 0, 0)); // 20 seed mid-stream
    vt.push_back(mk(0, 0, 0,    1, 1,     1,   1,  1, 8,    0, 0, 1)); // 21
    vt.push_back(mk(0, 0, 0,    1, 2,     0,   0,  1, 8,    0, 0, 1)); // 22 stall
    vt.push_back(mk(1, 0, 0,    1, 4,     1,   0,  0, 0,    0, 0, 0)); // 23 reset mid-stream
    vt.push_back(mk(1, 1, 50,   1, 4,     1,   0,  0, 0,    0, 0, 0)); // 24 rst beats seed
    vt.push_back(mk(0, 0, 0,    1, 4,     1,   0,  0, 0,    0, 0, 0)); // 25 idle after rst
    vt.push_back(mk(0, 0, 0,    1, 4,     1,   0,  0, 0,    0, 0, 0)); // 26 still idle

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].sl, vt[i].seed, vt[i].iv, vt[i].d, vt[i].ordy);
      @(negedge clk);
      chk($sformatf("row%0d in_ready_u", i), 32'(rdy_u), 32'(vt[i].e_rdy));
      chk($sformatf("row%0d in_ready_s", i), 32'(rdy_s), 32'(vt[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(ov_u), 32'(vt[i].e_ov));
      chk($sformatf("row%0d out_valid_s", i), 32'(ov_s), 32'(vt[i].e_ov));
      chk($sformatf("row%0d sum", i), 32'(sum_u), 32'(vt[i].e_sum));
      chk($sformatf("row%0d sum_s", i), 32'(sum_s), 32'(vt[i].e_sum));
      chk($sformatf("row%0d wrap_u", i), 32'(wr_u), 32'(vt[i].e_wu));
      chk($sformatf("row%0d wrap_s", i), 32'(wr_s), 32'(vt[i].e_ws));
      chk($sformatf("row%0d count_u", i), 32'(cnt_u), 32'(vt[i].e_cnt));
      csat = (vt[i].e_cnt > 7) ? 7 : vt[i].e_cnt;
      chk($sformatf("row%0d count_s", i), 32'(cnt_s), 32'(csat));
    end

    // Count saturation: 10 accepts on a 3-bit counter.
    drive(0, 1, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 1, 1, 1);
      @(negedge clk);
      chk("sat in_ready", 32'(rdy_s), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("sat sum", 32'(sum_u), 32'd10);
    chk("sat count_u", 32'(cnt_u), 32'd10);
    chk("sat count_s", 32'(cnt_s), 32'd7);
    chk("sat out_valid", 32'(ov_s), 32'd1);

    // Randomized traffic against the reference model
    drive(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 3000; n++) begin
      bit r, sl, iv, o;
      logic [7:0] s, d;
      r  = ($urandom_range(0, 59) == 0);
      sl = ($urandom_range(0, 13) == 0);
      iv = ($urandom_range(0, 3) != 0);
      o  = ($urandom_range(0, 2) != 0);
      s  = 8'($urandom);
      d  = 8'($urandom);
      drive(r, sl, s, iv, d, o);
      @(negedge clk);
      chk("rnd in_ready_u", 32'(rdy_u), 32'(model_ready(r, sl)));
      chk("rnd in_ready_s", 32'(rdy_s), 32'(model_ready(r, sl)));
      model_step(r, sl, int'(s), iv, int'(d), o);
      @(posedge clk);
      #1;
      chk("rnd out_valid_u", 32'(ov_u), 32'(m_ov));
      chk("rnd out_valid_s", 32'(ov_s), 32'(m_ov));
      chk("rnd sum_u", 32'(sum_u), 32'(m_sum));
      chk("rnd sum_s", 32'(sum_s), 32'(m_sum));
      chk("rnd wrap_u", 32'(wr_u), 32'(m_wu));
      chk("rnd wrap_s", 32'(wr_s), 32'(m_ws));
      chk("rnd count_u", 32'(cnt_u), 32'(m_cnt_u));
      chk("rnd count_s", 32'(cnt_s), 32'(m_cnt_s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delta_decoder.md
DELTA_DECODER -- requirements
Module: delta_decoder

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the width of Seed, DeltaIn and Sum.
REQ-002 The block SHALL have parameter CNTWIDTH, default 16, giving the width of Count.
REQ-003 The block SHALL have parameter SIGNED_DELTA, default 0, where 0 means deltas are unsigned and 1 means deltas are two's complement.
REQ-004 Clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Rst  input  1  is the reset, synchronous and active-high.
REQ-006 SeedLoad  input  1  loads a new reference value.
REQ-007 Seed  input  DATAWIDTH  is the reference value captured on SeedLoad.
REQ-008 InValid  input  1  means DeltaIn is valid.
REQ-009 DeltaIn  input  DATAWIDTH  is the difference sample produced by the upstream subtractor stage.
REQ-010 InReady  output  1  means the block accepts DeltaIn this cycle.
REQ-011 OutValid  output  1  means Sum is valid.
REQ-012 OutReady  input  1  means the downstream stage consumes Sum this cycle.
REQ-013 Sum  output  DATAWIDTH  is the reconstructed value.
REQ-014 Wrap  output  1  flags overflow on the addition that produced Sum.
REQ-015 Count  output  CNTWIDTH  is the number of deltas accepted since the last seed or reset.

Function
REQ-016 The block SHALL implement two states: IDLE (no reference held) and RUN (reference held in accumulator Acc).
REQ-017 On SeedLoad=1 in any state, the block SHALL set Acc to Seed, enter RUN, clear OutValid, clear Wrap and clear Count.
REQ-018 InReady SHALL equal (state==RUN) AND NOT SeedLoad AND (NOT OutValid OR OutReady), combinationally.
REQ-019 A delta SHALL be accepted only in a cycle where InValid=1 and InReady=1.
REQ-020 On accept, the block SHALL compute Acc+DeltaIn modulo 2^DATAWIDTH and write the result to both Acc and Sum, so that Sum is visible with OutValid=1 in the next cycle (1-cycle latency).
REQ-021 When SIGNED_DELTA=0, Wrap SHALL be the carry-out of the unsigned add.
REQ-022 When SIGNED_DELTA=1, Wrap SHALL be the two's-complement overflow: both operands have the same sign and the result sign differs.
REQ-023 Wrap SHALL be registered alongside Sum and SHALL describe only the current Sum.
REQ-024 When OutValid=1 and OutReady=0, Sum, Wrap and OutValid SHALL hold unchanged and no delta SHALL be accepted.
REQ-025 When OutValid=1, OutReady=1 and a delta is accepted in the same cycle, the new Sum SHALL replace the old one and OutValid SHALL stay 1 (full throughput, one sample per cycle).
REQ-026 When OutValid=1, OutReady=1 and no delta is accepted, OutValid SHALL go to 0 next cycle and Sum SHALL hold its value.
REQ-027 Count SHALL increment by 1 per accepted delta and SHALL saturate at 2^CNTWIDTH-1.
REQ-028 In IDLE, InValid SHALL be ignored and OutValid SHALL remain 0.
REQ-029 If SeedLoad and InValid are both 1 in the same cycle, the seed SHALL win and the delta SHALL not be accepted.

Reset
REQ-030 On Rst=1 at a clock edge, the block SHALL set state=IDLE, Acc=0, Sum=0, OutValid=0, Wrap=0 and Count=0.
REQ-031 Rst SHALL take priority over SeedLoad and over any handshake, including mid-stream, and any pending output SHALL be discarded.
REQ-032 InReady SHALL be 0 during reset and in the cycle after it.

Verification (DATAWIDTH=8)
REQ-033 Reset, then InValid=1 with DeltaIn=5 and no seed -> InReady=0, OutValid stays 0, Count=0.
REQ-034 Seed=10, then deltas 5 and 3 back-to-back with OutReady=1 -> Sum=15 then 18 on consecutive cycles, each one cycle after its accept, Wrap=0, Count=2.
REQ-035 SIGNED_DELTA=0, Seed=250, delta 10 -> Sum=4, Wrap=1; a following delta 1 -> Sum=5, Wrap=0.
REQ-036 SIGNED_DELTA=1, Seed=100, delta 0xF6 -> Sum=90, Wrap=0; Seed=120, delta 20 -> Sum=0x8C, Wrap=1.
REQ-037 Backpressure: Sum=15 pending with OutReady=0 for 3 cycles while InValid=1 -> InReady=0 and Sum=15 held; when OutReady=1 the next delta is accepted the same cycle.
REQ-038 SeedLoad=1 with Seed=7 mid-stream while InValid=1 and OutValid=1 -> delta rejected, OutValid=0 and Count=0 next cycle; then delta 1 -> Sum=8. Separately, Rst=1 mid-stream -> all outputs 0 and state IDLE.
